ssp_reg_arbiter: RTL and testbench

//  Shares the ssp_uart SSP register-access port (RA/WnR/DI/En/EOC/DO) between NREQ

---
 rtl/ssp_reg_arbiter.sv | 155 +++++++++++++++
 tb/tb_ssp_reg_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssp_reg_arbiter.sv
// Round-robin arbiter sharing the ssp_uart register-access port between NREQ requesters.
// Each access runs SSEL/setup -> En pulse -> EOC (read capture) -> one-cycle response.
module ssp_reg_arbiter #(
  parameter int NREQ      = 2,
  parameter int SETUP_CYC = 1,
  parameter int EN_CYC    = 2
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [NREQ-1:0]    Req_Valid,
  output logic [NREQ-1:0]    Req_Ready,
  input  logic [3*NREQ-1:0]  Req_RA,
  input  logic [NREQ-1:0]    Req_WnR,
  input  logic [12*NREQ-1:0] Req_DI,
  output logic [NREQ-1:0]    Rsp_Valid,
  output logic [11:0]        Rsp_DO,
  output logic               Rsp_Err,
  output logic               Busy,
  output logic               SSP_SSEL,
  output logic [2:0]         SSP_RA,
  output logic               SSP_WnR,
  output logic [11:0]        SSP_DI,
  output logic               SSP_En,
  output logic               SSP_EOC,
  input  logic [11:0]        SSP_DO
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int MAXC = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
  localparam int CW   = $clog2(MAXC) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ENABLE, S_EOC, S_RESP, S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gnt_q, gnt_d;
  logic [2:0]      ra_q, ra_d;
  logic            wnr_q, wnr_d;
  logic [11:0]     di_q, di_d;
  logic [11:0]     rdata_q, rdata_d;

  logic            gnt_found;
  logic [PW-1:0]   gnt_idx;
  logic [2:0]      gnt_ra;
  logic            ssel;

  // Rotating priority scan: first valid requester at or after ptr_q.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_found && Req_Valid[(int'(ptr_q) + i) % NREQ]) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'((int'(ptr_q) + i) % NREQ);
      end
    end
    gnt_ra = Req_RA[3*gnt_idx +: 3];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    ra_d      = ra_q;
    wnr_d     = wnr_q;
    di_d      = di_q;
    rdata_d   = rdata_q;
    Req_Ready = '0;

    unique case (state_q)
      S_IDLE: begin
        // Ready is held off while reset is asserted so no requester sees a phantom accept.
        if (Rst && gnt_found) begin
          Req_Ready[gnt_idx] = 1'b1;
          gnt_d   = gnt_idx;
          ra_d    = gnt_ra;
          wnr_d   = Req_WnR[gnt_idx];
          di_d    = Req_DI[12*gnt_idx +: 12];
          rdata_d = '0;
          if (gnt_ra > 3'd4) begin
            state_d = S_ERR;
          end else begin
            state_d = S_SETUP;
            cnt_d   = CW'(SETUP_CYC - 1);
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_ENABLE;
          cnt_d   = CW'(EN_CYC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_ENABLE: begin
        if (cnt_q == '0) state_d = S_EOC;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_EOC: begin
        state_d = S_RESP;
        if (!wnr_q) rdata_d = SSP_DO;
      end
      S_RESP, S_ERR: begin
        state_d = S_IDLE;
        ptr_d   = (gnt_q == PW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ssel      = (state_q == S_SETUP) || (state_q == S_ENABLE) || (state_q == S_EOC);
    Busy      = (state_q != S_IDLE);
    SSP_SSEL  = ssel;
    SSP_RA    = ssel ? ra_q  : 3'd0;
    SSP_WnR   = ssel ? wnr_q : 1'b0;
    SSP_DI    = ssel ? di_q  : 12'd0;
    SSP_En    = (state_q == S_ENABLE);
    SSP_EOC   = (state_q == S_EOC);
    Rsp_Valid = '0;
    if ((state_q == S_RESP) || (state_q == S_ERR)) Rsp_Valid[gnt_q] = 1'b1;
    Rsp_DO    = (state_q == S_RESP) ? rdata_q : 12'd0;
    Rsp_Err   = (state_q == S_ERR);
  end

  always_ff @(posedge Clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      ra_q    <= '0;
      wnr_q   <= 1'b0;
      di_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ra_q    <= ra_d;
      wnr_q   <= wnr_d;
      di_q    <= di_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_ssp_reg_arbiter.sv
// Self-checking bench for ssp_reg_arbiter: transaction-level reference model plus
// directed scenarios (write, read-back, contention, illegal RA, mid-access reset, withdrawal).
module tb_ssp_reg_arbiter;

  localparam int NREQ = 2;
  localparam int S    = 1;
  localparam int E    = 2;

  logic              Clk = 1'b0;
  logic              Rst;
  logic [NREQ-1:0]   Req_Valid;
  logic [NREQ-1:0]   Req_Ready;
  logic [3*NREQ-1:0] Req_RA;
  logic [NREQ-1:0]   Req_WnR;
  logic [12*NREQ-1:0] Req_DI;
  logic [NREQ-1:0]   Rsp_Valid;
  logic [11:0]       Rsp_DO;
  logic              Rsp_Err;
  logic              Busy;
  logic              SSP_SSEL;
  logic [2:0]        SSP_RA;
  logic              SSP_WnR;
  logic [11:0]       SSP_DI;
  logic              SSP_En;
  logic              SSP_EOC;
  logic [11:0]       SSP_DO;

  always #5 Clk = ~Clk;

  ssp_reg_arbiter #(.NREQ(NREQ), .SETUP_CYC(S), .EN_CYC(E)) dut (
    .Clk(Clk), .Rst(Rst),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_RA(Req_RA),
    .Req_WnR(Req_WnR), .Req_DI(Req_DI),
    .Rsp_Valid(Rsp_Valid), .Rsp_DO(Rsp_DO), .Rsp_Err(Rsp_Err), .Busy(Busy),
    .SSP_SSEL(SSP_SSEL), .SSP_RA(SSP_RA), .SSP_WnR(SSP_WnR), .SSP_DI(SSP_DI),
    .SSP_En(SSP_En), .SSP_EOC(SSP_EOC), .SSP_DO(SSP_DO)
  );

  // Simple ssp_uart register file standing in for the slave.
  logic [11:0] slv [0:7] = '{default: 12'h000};
  assign SSP_DO = slv[SSP_RA];
  always @(posedge Clk) if (SSP_EOC && SSP_WnR) slv[SSP_RA] <= SSP_DI;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level, cycle offsets) ----------------
  bit          started = 1'b0;
  always @(posedge Clk) if (!Rst) started <= 1'b1;

  bit          m_busy = 1'b0;
  bit          m_err  = 1'b0;
  int          m_phase = 0;
  int          m_g = 0;
  int          m_ptr = 0;
  logic [2:0]  m_ra = '0;
  logic        m_wnr = 1'b0;
  logic [11:0] m_di = '0;
  logic [11:0] exp_regs [0:7] = '{default: 12'h000};
  logic [NREQ-1:0] acc_seen = '0;

  always @(negedge Clk) begin
    logic [NREQ-1:0] e_ready, e_rv;
    logic e_busy, e_sel, e_en, e_eoc, e_err, e_wnr;
    logic [2:0]  e_ra;
    logic [11:0] e_di, e_do;
    int fg;
    if (started) begin
      fg = -1;
      for (int i = 0; i < NREQ; i++)
        if (fg < 0 && Req_Valid[(m_ptr + i) % NREQ]) fg = (m_ptr + i) % NREQ;
      e_ready = '0; e_rv = '0; e_busy = 0; e_sel = 0; e_en = 0; e_eoc = 0;
      e_err = 0; e_wnr = 0; e_ra = '0; e_di = '0; e_do = '0;
      if (!m_busy) begin
        if (Rst && fg >= 0) e_ready[fg] = 1'b1;
      end else begin
        e_busy = 1'b1;
        if (m_err) begin
          e_rv[m_g] = 1'b1;
          e_err     = 1'b1;
        end else if (m_phase <= S + E + 1) begin
          e_sel = 1'b1; e_ra = m_ra; e_wnr = m_wnr; e_di = m_di;
          e_en  = (m_phase > S) && (m_phase <= S + E);
          e_eoc = (m_phase == S + E + 1);
        end else begin
          e_rv[m_g] = 1'b1;
          e_do      = m_wnr ? 12'h000 : exp_regs[m_ra];
        end
      end
      check("ready", 64'(Req_Ready), 64'(e_ready));
      check("busy", 64'(Busy), 64'(e_busy));
      check("rsp", 64'({Rsp_Valid, Rsp_Err, Rsp_DO}), 64'({e_rv, e_err, e_do}));
      check("ssp", 64'({SSP_SSEL, SSP_En, SSP_EOC, SSP_WnR, SSP_RA, SSP_DI}),
                   64'({e_sel, e_en, e_eoc, e_wnr, e_ra, e_di}));
      if (!Rst) begin
        m_busy = 1'b0;
        m_ptr  = 0;
      end else if (!m_busy) begin
        if (fg >= 0) begin
          m_busy = 1'b1; m_phase = 1; m_g = fg;
          m_ra   = Req_RA[3*fg +: 3];
          m_wnr  = Req_WnR[fg];
          m_di   = Req_DI[12*fg +: 12];
          m_err  = (Req_RA[3*fg +: 3] > 3'd4);
        end
      end else if (m_err || m_phase == S + E + 2) begin
        m_busy = 1'b0;
        m_ptr  = (m_g + 1) % NREQ;
        if (!m_err && m_wnr) exp_regs[m_ra] = m_di;
      end else begin
        m_phase++;
      end
    end
    acc_seen = Req_Valid & Req_Ready;
  end

  // ---------------- directed helpers ----------------
  task automatic set_req(input int idx, input logic [2:0] ra, input logic wnr, input logic [11:0] di);
    Req_RA[3*idx +: 3]  = ra;
    Req_WnR[idx]        = wnr;
    Req_DI[12*idx +: 12] = di;
    Req_Valid[idx]      = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(negedge Clk);
      if (!Busy) begin ok = 1'b1; break; end
    end
    check(name, 64'(ok), 64'd1);
  endtask

  // Runs one access and reports what the SSP port and response looked like.
  task automatic do_access(input int idx, input logic [2:0] ra, input logic wnr,
                           input logic [11:0] di, input string tag,
                           output int n, output logic [11:0] rdo, output logic rerr,
                           output int sel_c, output int en_c, output int eoc_c,
                           output int di_bad);
    bit ok = 1'b0;
    n = 0; rdo = 'x; rerr = 'x; sel_c = 0; en_c = 0; eoc_c = 0; di_bad = 0;
    @(posedge Clk); #1;
    set_req(idx, ra, wnr, di);
    for (int t = 0; t < 20; t++) begin
      @(negedge Clk);
      if (Req_Valid[idx] && Req_Ready[idx]) begin ok = 1'b1; break; end
    end
    check({tag, "_accept"}, 64'(ok), 64'd1);
    @(posedge Clk); #1;
    Req_Valid[idx] = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(negedge Clk);
      n++;
      if (SSP_SSEL) sel_c++;
      if (SSP_En)   en_c++;
      if (SSP_EOC)  eoc_c++;
      if (SSP_SSEL && SSP_DI !== di) di_bad++;
      if (Rsp_Valid[idx]) begin rdo = Rsp_DO; rerr = Rsp_Err; ok = 1'b1; break; end
    end
    check({tag, "_rsp_seen"}, 64'(ok), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  int n, sel_c, en_c, eoc_c, di_bad;
  logic [11:0] rdo;
  logic rerr;

  initial begin
    int ng, idle, multi, rdy0, rsp0;
    logic [3:0] gl;
    logic [NREQ-1:0] first_rdy;
    bit ok;

    Rst = 1'b0; Req_Valid = '0; Req_RA = '0; Req_WnR = '0; Req_DI = '0;
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b1;
    @(negedge Clk);
    check("reset_outputs", 64'({Req_Ready, Rsp_Valid, Rsp_Err, Rsp_DO, Busy, SSP_SSEL,
                                SSP_RA, SSP_WnR, SSP_DI, SSP_En, SSP_EOC}), 64'd0);

    // T1: write; Rsp_Valid lands on the 4th edge after the accepting edge (5 negedges on).
    do_access(0, 3'd0, 1'b1, 12'h5A3, "t1", n, rdo, rerr, sel_c, en_c, eoc_c, di_bad);
    check("t1_rsp_cycle", 64'(n), 64'd5);
    check("t1_ssel_cycles", 64'(sel_c), 64'd4);
    check("t1_en_cycles", 64'(en_c), 64'd2);
    check("t1_eoc_cycles", 64'(eoc_c), 64'd1);
    check("t1_di_stable", 64'(di_bad), 64'd0);
    check("t1_rsp_do", 64'({rerr, rdo}), 64'h0000);

    // T2: read back through requester 1.
    do_access(1, 3'd0, 1'b0, 12'h000, "t2", n, rdo, rerr, sel_c, en_c, eoc_c, di_bad);
    check("t2_rsp_do", 64'({rerr, rdo}), 64'h05A3);

    // T4: illegal RA, error response the cycle after accept with no SSP activity.
    do_access(0, 3'd6, 1'b0, 12'h000, "t4", n, rdo, rerr, sel_c, en_c, eoc_c, di_bad);
    check("t4_rsp_cycle", 64'(n), 64'd1);
    check("t4_no_ssp", 64'(sel_c + en_c + eoc_c), 64'd0);
    check("t4_err", 64'({rerr, rdo}), 64'h1000);

    // T3: both requesters valid from reset.
    @(posedge Clk); #1;
    Rst = 1'b0;
    set_req(0, 3'd1, 1'b0, 12'h000);
    set_req(1, 3'd1, 1'b0, 12'h000);
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b1;
    ng = 0; idle = 0; multi = 0; gl = '0;
    for (int t = 0; t < 80 && ng < 4; t++) begin
      @(negedge Clk);
      if ($countones(Req_Ready) > 1) multi++;
      if (ng > 0 && !Busy) idle++;
      if (|Req_Ready) begin gl[ng] = Req_Ready[1]; ng++; end
    end
    @(posedge Clk); #1;
    Req_Valid = '0;
    check("t3_grant_count", 64'(ng), 64'd4);
    check("t3_grant_order", 64'(gl), 64'b1010);
    check("t3_one_ready", 64'(multi), 64'd0);
    check("t3_idle_gaps", 64'(idle), 64'd3);
    wait_idle("t3_drain");

    // T5: reset during ENABLE with requester 1 pending.
    @(posedge Clk); #1;
    set_req(0, 3'd2, 1'b1, 12'h111);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge Clk);
      if (Req_Ready[0]) begin ok = 1'b1; break; end
    end
    check("t5_accept0", 64'(ok), 64'd1);
    @(posedge Clk); #1;
    Req_Valid[0] = 1'b0;
    set_req(1, 3'd1, 1'b0, 12'h000);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge Clk);
      if (SSP_En) begin ok = 1'b1; break; end
    end
    check("t5_enable_seen", 64'(ok), 64'd1);
    @(posedge Clk); #1 Rst = 1'b0;
    @(posedge Clk); #1 Rst = 1'b1;
    @(negedge Clk);
    check("t5_after_reset", 64'({Rsp_Valid, Rsp_Err, Rsp_DO, Busy, SSP_SSEL, SSP_RA,
                                 SSP_WnR, SSP_DI, SSP_En, SSP_EOC}), 64'd0);
    check("t5_first_grant", 64'(Req_Ready), 64'b10);
    @(posedge Clk); #1;
    Req_Valid[1] = 1'b0;
    rsp0 = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge Clk);
      if (Rsp_Valid[0]) rsp0++;
    end
    check("t5_no_rsp0", 64'(rsp0), 64'd0);
    check("t5_wrt_abandoned", 64'(slv[2]), 64'h000);

    // T6: requester 0 pulses Valid for one cycle while busy.
    @(posedge Clk); #1;
    set_req(1, 3'd4, 1'b0, 12'h000);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge Clk);
      if (Req_Ready[1]) begin ok = 1'b1; break; end
    end
    check("t6_accept1", 64'(ok), 64'd1);
    @(posedge Clk); #1;
    Req_Valid[1] = 1'b0;
    set_req(0, 3'd0, 1'b0, 12'h000);
    @(posedge Clk); #1;
    Req_Valid[0] = 1'b0;
    rdy0 = 0;
    for (int t = 0; t < 15; t++) begin
      @(negedge Clk);
      if (Req_Ready[0]) rdy0++;
    end
    check("t6_never_granted", 64'(rdy0), 64'd0);

    // Randomized traffic with occasional resets; the model checks every cycle.
    for (int c = 0; c < 1500; c++) begin
      @(posedge Clk); #1;
      Rst = ($urandom_range(199) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (acc_seen[i] || !Req_Valid[i]) begin
          if ($urandom_range(2) != 0)
            set_req(i, ($urandom_range(7) == 0) ? 3'($urandom_range(7, 5)) : 3'($urandom_range(4)),
                    1'($urandom_range(1)), 12'($urandom));
          else
            Req_Valid[i] = 1'b0;
        end else if ($urandom_range(15) == 0) begin
          Req_Valid[i] = 1'b0;
        end
      end
    end
    @(posedge Clk); #1;
    Rst = 1'b1;
    Req_Valid = '0;
    wait_idle("final_drain");
    repeat (2) @(negedge Clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
